// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache. It serves single-word fetches from
// the CPU and refills whole lines from a block-wide instruction memory.
module icache_fetch #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 32,
    parameter int LINES           = 8,
    localparam int BLOCK_SIZE     = WORD_SIZE * WORDS_PER_BLOCK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [WORD_SIZE-1:0]  cpu_addr,
    output logic                  cpu_busy,
    output logic                  cpu_ready,
    output logic [WORD_SIZE-1:0]  cpu_data,
    input  logic                  flush,
    output logic                  mem_rd,
    output logic [WORD_SIZE-1:0]  mem_addr,
    input  logic                  mem_valid,
    input  logic [BLOCK_SIZE-1:0] mem_block,
    output logic [1:0]            fsm_state
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        REPLY = 2'd2
    } state_t;

    state_t state;

    logic [LINES-1:0]                               valid;
    logic [TAG_W-1:0]                               tags  [LINES];
    logic [WORDS_PER_BLOCK-1:0][WORD_SIZE-1:0]      lines [LINES];
    logic [WORD_SIZE-1:0]                           req_addr;

    logic [IDX_W-1:0] idx_in;
    logic [TAG_W-1:0] tag_in;
    logic [OFF_W-1:0] off_in;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-1:0] req_off;
    logic             hit;

    // CPU handshake: a request is taken only on an edge where cpu_req=1 and
    // cpu_busy=0; the answer is a one-cycle cpu_ready pulse carrying cpu_data.
    // Memory handshake: mem_rd/mem_addr are held until the edge with mem_valid=1.
    assign idx_in  = cpu_addr[OFF_W +: IDX_W];
    assign tag_in  = cpu_addr[WORD_SIZE-1 -: TAG_W];
    assign off_in  = cpu_addr[OFF_W-1:0];
    assign req_idx = req_addr[OFF_W +: IDX_W];
    assign req_tag = req_addr[WORD_SIZE-1 -: TAG_W];
    assign req_off = req_addr[OFF_W-1:0];
    assign hit     = valid[idx_in] && (tags[idx_in] == tag_in);

    assign cpu_busy  = (state != IDLE) || flush;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            req_addr  <= '0;
            cpu_ready <= 1'b0;
            cpu_data  <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (cpu_req) begin
                        req_addr <= cpu_addr;
                        if (hit) begin
                            cpu_ready <= 1'b1;
                            cpu_data  <= lines[idx_in][off_in];
                        end else begin
                            state    <= FETCH;
                            mem_rd   <= 1'b1;
                            mem_addr <= {cpu_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                FETCH: begin
                    if (mem_valid) begin
                        lines[req_idx] <= mem_block;
                        tags[req_idx]  <= req_tag;
                        valid[req_idx] <= 1'b1;
                        mem_rd         <= 1'b0;
                        state          <= REPLY;
                    end
                end
                REPLY: begin
                    // The line was written on the previous edge, so it reads back here.
                    cpu_ready <= 1'b1;
                    cpu_data  <= lines[req_idx][req_off];
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: stimulus pushes expected words and arrival
// cycles into a queue, a negedge monitor pops and compares on every cpu_ready.
module tb_icache_fetch;

    localparam int W     = 32;
    localparam int WPB   = 32;
    localparam int BLOCK = W * WPB;

    logic             clk = 1'b0;
    logic             rst;
    logic             cpu_req;
    logic [W-1:0]     cpu_addr;
    logic             cpu_busy;
    logic             cpu_ready;
    logic [W-1:0]     cpu_data;
    logic             flush;
    logic             mem_rd;
    logic [W-1:0]     mem_addr;
    logic             mem_valid;
    logic [BLOCK-1:0] mem_block;
    logic [1:0]       fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    icache_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_busy  (cpu_busy),
        .cpu_ready (cpu_ready),
        .cpu_data  (cpu_data),
        .flush     (flush),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_block (mem_block),
        .fsm_state (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory image: word at address a holds a-28, so block 128 word k = k+100.
    function automatic logic [BLOCK-1:0] make_block(input logic [W-1:0] base);
        logic [BLOCK-1:0] b;
        for (int k = 0; k < WPB; k++) b[k*W +: W] = base + W'(k) - 32'd28;
        return b;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && cpu_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: got data %0d expected no cpu_ready (cycle %0d)", cpu_data, cyc);
            end else begin
                check("cpu_data", cpu_data, exp_q.pop_front());
                check("ready_cycle", W'(cyc), W'(exp_cyc_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic [W-1:0] addr, input logic [W-1:0] exp_data, input int lat);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        exp_q.push_back(exp_data);
        exp_cyc_q.push_back(cyc + lat);
    endtask

    // Miss with memory answering so that mem_valid is sampled 'delay' edges
    // after the request edge; optionally keep hammering cpu_req while busy.
    task automatic do_miss(input logic [W-1:0] addr, input logic [W-1:0] exp_base,
                           input logic [W-1:0] exp_data, input int delay, input bit hammer);
        issue(addr, exp_data, delay + 2);
        tick;
        cpu_req = hammer;
        check("miss_mem_rd", W'(mem_rd), 1);
        check("miss_mem_addr", mem_addr, exp_base);
        check("miss_busy", W'(cpu_busy), 1);
        for (int i = 1; i < delay; i++) begin
            if (hammer) cpu_addr = W'($urandom_range(0, 4095));
            tick;
            check("wait_mem_rd", W'(mem_rd), 1);
            check("wait_mem_addr", mem_addr, exp_base);
        end
        mem_valid = 1'b1;
        mem_block = make_block(exp_base);
        tick;
        mem_valid = 1'b0;
        check("mem_rd_drop", W'(mem_rd), 0);
        check("reply_busy", W'(cpu_busy), 1);
        tick;
        cpu_req = 1'b0;
        check("back_idle_busy", W'(cpu_busy), 0);
        tick;
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
        mem_valid = 1'b0; mem_block = '0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        check("rst_ready", W'(cpu_ready), 0);
        check("rst_data", cpu_data, 0);
        check("rst_mem_rd", W'(mem_rd), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", W'(cpu_busy), 0);
        check("rst_state", W'(fsm_state), 0);

        // Cold miss, 3-cycle memory wait
        do_miss(32'd129, 32'd128, 32'd101, 3, 1'b0);

        // Back-to-back hits
        issue(32'd130, 32'd102, 1);
        tick;
        issue(32'd159, 32'd131, 1);
        check("hit_no_mem_rd", W'(mem_rd), 0);
        tick;
        cpu_req = 1'b0;
        check("hit_no_mem_rd2", W'(mem_rd), 0);
        tick;
        check("data_hold", cpu_data, 32'd131);

        // Conflict on index 4
        do_miss(32'd385, 32'd384, 32'd357, 2, 1'b0);
        do_miss(32'd129, 32'd128, 32'd101, 2, 1'b0);

        // Flush pulse, then the line misses again
        flush = 1'b1;
        #1;
        check("flush_busy", W'(cpu_busy), 1);
        tick;
        flush = 1'b0;
        do_miss(32'd130, 32'd128, 32'd102, 2, 1'b0);

        // Flush with a simultaneous request: not accepted
        flush = 1'b1; cpu_req = 1'b1; cpu_addr = 32'd130;
        tick;
        flush = 1'b0; cpu_req = 1'b0;
        check("flush_req_no_mem_rd", W'(mem_rd), 0);
        tick; tick;
        do_miss(32'd130, 32'd128, 32'd102, 1, 1'b0);

        // Reset two cycles into a FETCH, late mem_valid afterwards
        cpu_req = 1'b1; cpu_addr = 32'd641;
        tick;
        cpu_req = 1'b0;
        check("pre_rst_mem_rd", W'(mem_rd), 1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mem_valid = 1'b1;
        mem_block = make_block(32'd640);
        check("rst_fetch_mem_rd", W'(mem_rd), 0);
        check("rst_fetch_state", W'(fsm_state), 0);
        tick;
        mem_valid = 1'b0;
        check("late_valid_mem_rd", W'(mem_rd), 0);
        tick; tick;
        do_miss(32'd129, 32'd128, 32'd101, 2, 1'b0);

        // Requests hammered during a 5-cycle wait: exactly one reply
        do_miss(32'd1000, 32'd992, 32'd972, 5, 1'b1);

        repeat (4) tick;
        check("queue_drained", W'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
